// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_SW = 32;

  typedef enum logic [2:0] {LOAD, ISSUE, WAIT, RESULT, DONE} state_t;

  typedef logic signed [DEF_DW-1:0] elem_t;
  typedef logic signed [DEF_SW-1:0] sum_t;

  // Index width that never collapses to zero bits, so N=1 still has a 1-bit port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// Loads A and B element-serially, feeds each row/column pair to an external
// dot_product unit, and streams C[i][j] out over a valid/ready port.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int SW     = 32,
  parameter int DP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [DW-1:0]        load_data,
  output logic                 dp_enable,
  output logic [N*DW-1:0]      dp_inp1,
  output logic [N*DW-1:0]      dp_inp2,
  input  logic [SW-1:0]        dp_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SW-1:0]        res_data,
  output logic [idx_w(N)-1:0]  res_row,
  output logic [idx_w(N)-1:0]  res_col,
  output logic                 done
);

  localparam int NN = N * N;
  localparam int IW = idx_w(N);
  localparam int EW = idx_w(2 * NN);
  localparam int CW = idx_w(DP_LAT);

  state_t             state_reg;
  logic [EW-1:0]      e_reg;
  logic [IW-1:0]      i_reg;
  logic [IW-1:0]      j_reg;
  logic [CW-1:0]      wait_reg;
  logic [NN*DW-1:0]   a_reg;
  logic [NN*DW-1:0]   b_reg;
  logic [NN*DW-1:0]   a_next;
  logic [NN*DW-1:0]   b_next;
  logic [N*DW-1:0]    op1_next;
  logic [N*DW-1:0]    op2_next;
  logic               load_fire;
  logic               res_fire;
  logic               last_beat;
  logic               j_wrap;
  logic               last_prod;
  int                 nxt_i;
  int                 nxt_j;

  assign load_fire = (state_reg == LOAD) && load_valid && load_ready;
  assign res_fire  = (state_reg == RESULT) && res_valid && res_ready;
  assign last_beat = (e_reg == EW'(2 * NN - 1));
  assign j_wrap    = (j_reg == IW'(N - 1));
  assign last_prod = j_wrap && (i_reg == IW'(N - 1));

  // Storage including this cycle's beat, so the first operand fetch sees the final element.
  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    if (load_fire) begin
      if (int'(e_reg) < NN) a_next[int'(e_reg)*DW +: DW] = load_data;
      else                  b_next[(int'(e_reg) - NN)*DW +: DW] = load_data;
    end
  end

  // Coordinates of the product that the next ISSUE will present.
  always_comb begin
    nxt_i = 0;
    nxt_j = 0;
    if (state_reg == RESULT && !last_prod) begin
      nxt_i = j_wrap ? int'(i_reg) + 1 : int'(i_reg);
      nxt_j = j_wrap ? 0 : int'(j_reg) + 1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gather
    assign op1_next[gi*DW +: DW] = a_next[(nxt_i*N + gi)*DW +: DW];
    assign op2_next[gi*DW +: DW] = b_next[(gi*N + nxt_j)*DW +: DW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= LOAD;
      e_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      wait_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      load_ready <= 1'b1;
      dp_enable  <= 1'b0;
      dp_inp1    <= '0;
      dp_inp2    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_row    <= '0;
      res_col    <= '0;
      done       <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      dp_enable <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (load_fire) begin
            e_reg <= e_reg + 1'b1;
            if (last_beat) begin
              state_reg  <= ISSUE;
              load_ready <= 1'b0;
              dp_enable  <= 1'b1;
              dp_inp1    <= op1_next;
              dp_inp2    <= op2_next;
            end
          end
        end
        ISSUE: begin
          wait_reg  <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (wait_reg == CW'(DP_LAT - 1)) begin
            res_data  <= dp_sum;
            res_row   <= i_reg;
            res_col   <= j_reg;
            res_valid <= 1'b1;
            state_reg <= RESULT;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        RESULT: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            if (last_prod) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              i_reg     <= IW'(nxt_i);
              j_reg     <= IW'(nxt_j);
              state_reg <= ISSUE;
              dp_enable <= 1'b1;
              dp_inp1   <= op1_next;
              dp_inp2   <= op2_next;
            end
          end
        end
        DONE: begin
          e_reg      <= '0;
          i_reg      <= '0;
          j_reg      <= '0;
          load_ready <= 1'b1;
          state_reg  <= LOAD;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: behavioural dot-product partner, scoreboard of expected
// C entries, plus an N=1 / DP_LAT=3 instance driven by a constant-result stub.
`timescale 1ns/1ps
module tb_matmul_sequencer;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int SW = 32;
  localparam int NN = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic            load_valid, load_ready, dp_enable, res_valid, res_ready, done;
  logic [DW-1:0]   load_data;
  logic [N*DW-1:0] dp_inp1, dp_inp2;
  logic [SW-1:0]   dp_sum = '0;
  logic [SW-1:0]   res_data;
  logic [0:0]      res_row, res_col;

  matmul_sequencer #(.N(N), .DW(DW), .SW(SW), .DP_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .dp_enable(dp_enable), .dp_inp1(dp_inp1), .dp_inp2(dp_inp2), .dp_sum(dp_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .done(done)
  );

  logic          load_valid2, load_ready2, dp_enable2, res_valid2, res_ready2, done2;
  logic [DW-1:0] load_data2, dp_inp1_2, dp_inp2_2;
  logic [SW-1:0] dp_sum2, res_data2;
  logic [0:0]    res_row2, res_col2;
  logic [2:0]    pipe2 = '0;

  matmul_sequencer #(.N(1), .DW(DW), .SW(SW), .DP_LAT(3)) dut2 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid2), .load_ready(load_ready2), .load_data(load_data2),
    .dp_enable(dp_enable2), .dp_inp1(dp_inp1_2), .dp_inp2(dp_inp2_2), .dp_sum(dp_sum2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .res_row(res_row2), .res_col(res_col2), .done(done2)
  );

  // Stub partner: result appears exactly three cycles after the strobe, garbage otherwise.
  always @(posedge clk) pipe2 <= {pipe2[1:0], dp_enable2};
  assign dp_sum2 = pipe2[2] ? 32'h55 : 32'hBAD0_BAD0;

  function automatic int dot(input logic [N*DW-1:0] x, input logic [N*DW-1:0] y);
    int s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += int'(signed'(x[k*DW +: DW])) * int'(signed'(y[k*DW +: DW]));
    return s;
  endfunction

  // One-cycle-latency dot product; the sum is only valid in the cycle after the strobe.
  always @(posedge clk) dp_sum <= dp_enable ? 32'(dot(dp_inp1, dp_inp2)) : 32'hDEAD_BEEF;

  typedef struct { int i; int j; int v; } res_t;
  int   mA [N][N];
  int   mB [N][N];
  res_t exp_q[$];
  int   got[$];
  int   tests = 0;
  int   fails = 0;
  int   n_issue, n_done, n_writes, cyc, issue_cyc;
  logic prev_valid, prev_stall;
  logic [SW-1:0] held_data;
  logic held_row, held_col;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      cyc++;
      if (load_valid && load_ready) n_writes++;
      if (dp_enable) begin
        n_issue++;
        issue_cyc = cyc;
        if (exp_q.size() == 0) check("spurious_issue", 1, 0);
        else begin
          for (int k = 0; k < N; k++) begin
            check("dp_inp1", signed'(dp_inp1[k*DW +: DW]), mA[exp_q[0].i][k]);
            check("dp_inp2", signed'(dp_inp2[k*DW +: DW]), mB[k][exp_q[0].j]);
          end
        end
      end
      if (res_valid && !prev_valid) check("latency", cyc - issue_cyc, 2);
      if (res_valid && prev_stall) begin
        check("hold_data", res_data, held_data);
        check("hold_row", res_row, held_row);
        check("hold_col", res_col, held_col);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_row", res_row, e.i);
          check("res_col", res_col, e.j);
          check("res_data", signed'(res_data), e.v);
          got.push_back(int'(signed'(res_data)));
        end
      end
      if (done) n_done++;
      prev_valid = res_valid;
      prev_stall = res_valid && !res_ready;
      held_data  = res_data;
      held_row   = res_row;
      held_col   = res_col;
    end
  end

  task automatic set_mats(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    mA[0][0] = a0; mA[0][1] = a1; mA[1][0] = a2; mA[1][1] = a3;
    mB[0][0] = b0; mB[0][1] = b1; mB[1][0] = b2; mB[1][1] = b3;
  endtask

  task automatic check_reset_outputs();
    check("rst_load_ready", load_ready, 1);
    check("rst_dp_enable", dp_enable, 0);
    check("rst_dp_inp1", dp_inp1, 0);
    check("rst_dp_inp2", dp_inp2, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_row", res_row, 0);
    check("rst_res_col", res_col, 0);
    check("rst_done", done, 0);
  endtask

  // mode: 0 steady load, 1 toggled load plus junk load_valid during compute, 2 random.
  // stall: >=0 cycles of res_ready low per result, <0 random. abort_at>0: reset in that product's WAIT.
  task automatic run(input int mode, input int stall, input int abort_at);
    int   k, guard, cnt, v;
    logic rdy;
    res_t r;
    exp_q.delete();
    got.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        v = 0;
        for (int m = 0; m < N; m++) v += mA[i][m] * mB[m][j];
        r.i = i; r.j = j; r.v = v;
        exp_q.push_back(r);
      end
    n_issue = 0; n_done = 0; n_writes = 0;
    k = 0; guard = 0;
    while (k < 2*NN && guard < 500) begin
      case (mode)
        0:       load_valid = 1'b1;
        1:       load_valid = (guard % 2 == 0);
        default: load_valid = 1'($urandom_range(0, 1));
      endcase
      load_data = (k < NN) ? DW'(mA[k/N][k%N]) : DW'(mB[(k-NN)/N][(k-NN)%N]);
      rdy = load_ready;
      @(posedge clk); #1;
      if (load_valid && rdy) k++;
      guard++;
    end
    load_valid = 1'b0;
    check("load_beats", k, 2*NN);
    check("load_ready_after_load", load_ready, 0);
    cnt = 0; guard = 0;
    while (n_done == 0 && guard < 1000) begin
      if (mode != 0) begin
        load_valid = 1'b1;
        load_data  = DW'($urandom);
      end
      if (stall < 0) res_ready = 1'($urandom_range(0, 1));
      else begin
        res_ready = res_valid && (cnt >= stall);
        cnt = res_ready ? 0 : (res_valid ? cnt + 1 : 0);
      end
      if (abort_at > 0 && n_issue == abort_at && !res_valid) begin
        #2 reset = 1'b0;
        #1;
        check_reset_outputs();
        check("no_done_on_abort", n_done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        prev_valid = 1'b0; prev_stall = 1'b0;
        load_valid = 1'b0; res_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      guard++;
    end
    load_valid = 1'b0;
    res_ready  = 1'b0;
    check("done_seen", n_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", n_done, 1);
    check("issue_count", n_issue, NN);
    check("write_count", n_writes, 2*NN);
    check("queue_empty", exp_q.size(), 0);
    check("load_ready_idle", load_ready, 1);
  endtask

  task automatic check_lit(input int l0, input int l1, input int l2, input int l3);
    int lit [4];
    lit = '{l0, l1, l2, l3};
    check("result_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) check("literal_result", got[k], lit[k]);
  endtask

  task automatic test_lat3();
    int t, t_issue;
    load_valid2 = 1'b1; load_data2 = 8'd5;
    @(posedge clk); #1;
    load_data2 = 8'hFD;
    @(posedge clk); #1;
    load_valid2 = 1'b0;
    check("lat3_load_ready", load_ready2, 0);
    t = 0; t_issue = -1;
    while (!res_valid2 && t < 50) begin
      if (dp_enable2 && t_issue < 0) begin
        t_issue = t;
        check("lat3_inp1", signed'(dp_inp1_2), 5);
        check("lat3_inp2", signed'(dp_inp2_2), -3);
      end
      @(posedge clk); #1;
      t++;
    end
    check("lat3_valid", res_valid2, 1);
    check("lat3_latency", t - t_issue, 4);
    check("lat3_data", res_data2, 32'h55);
    check("lat3_row", res_row2, 0);
    check("lat3_col", res_col2, 0);
    res_ready2 = 1'b1;
    @(posedge clk); #1;
    res_ready2 = 1'b0;
    check("lat3_done", done2, 1);
    check("lat3_valid_drop", res_valid2, 0);
    @(posedge clk); #1;
    check("lat3_done_pulse", done2, 0);
    check("lat3_ready_back", load_ready2, 1);
  endtask

  initial begin
    reset = 1'b0;
    load_valid = 1'b0; load_data = '0; res_ready = 1'b0;
    load_valid2 = 1'b0; load_data2 = '0; res_ready2 = 1'b0;
    prev_valid = 1'b0; prev_stall = 1'b0;
    cyc = 0; issue_cyc = 0; n_issue = 0; n_done = 0; n_writes = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    check("rst2_load_ready", load_ready2, 1);
    check("rst2_res_valid", res_valid2, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    set_mats(1, 2, 3, 4, 1, 2, 3, 4);
    run(0, 0, 0); check_lit(7, 10, 15, 22);
    run(0, 5, 0); check_lit(7, 10, 15, 22);
    run(1, 0, 0); check_lit(7, 10, 15, 22);

    set_mats(-1, 2, 3, -4, 1, 0, 0, 1);
    run(2, 0, 0); check_lit(-1, 2, 3, -4);
    set_mats(127, 127, 127, 127, -128, -128, -128, -128);
    run(0, 0, 0); check_lit(-32512, -32512, -32512, -32512);

    set_mats(1, 2, 3, 4, 1, 2, 3, 4);
    run(0, 0, 3);
    run(0, 0, 0); check_lit(7, 10, 15, 22);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mA[i][j] = int'($urandom_range(0, 255)) - 128;
          mB[i][j] = int'($urandom_range(0, 255)) - 128;
        end
      run(2, -1, 0);
    end

    test_lat3();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Initiator side of the dot_product interface. Loads two NxN matrices A and B. For every (i,j) it drives row i of A and column j of B onto the dot_product operand ports and captures the returned sum. It then streams C[i][j] out through a valid/ready port. It sits between the host load path and a dot_product instance; the two are wired together at top level.

Parameters:
N, 2, matrix dimension (N>=1)
DW, 8, signed element width
SW, 32, signed sum width (must hold N*(2^(DW-1))^2)
DP_LAT, 1, cycles from dp_enable until dp_sum is valid (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  load beat valid
load_ready  out  1  load beat accepted
load_data  in  DW  element; order is A row-major, then B row-major (2*N*N beats)
dp_enable  out  1  one-cycle operand strobe to dot_product
dp_inp1  out  N*DW  row i of A, element k at bits [k*DW +: DW]
dp_inp2  out  N*DW  column j of B, same packing
dp_sum  in  SW  dot_product result
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  SW  C[i][j]
res_row  out  $clog2(N) (min 1)  i
res_col  out  $clog2(N) (min 1)  j
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD; all counters=0; A and B storage=0; load_ready=1; dp_enable=0; dp_inp1/dp_inp2=0; res_valid=0; res_data=0; res_row/res_col=0; done=0.
- FSM states: LOAD, ISSUE, WAIT, RESULT, DONE.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid&&load_ready writes load_data at element counter e, then e++.
  - e<N*N writes A[e/N][e%N]; otherwise writes B.
  - On the beat with e=2*N*N-1, go to ISSUE; load_ready drops next cycle.
- ISSUE:
  - dp_enable=1 for exactly one cycle.
  - dp_inp1/dp_inp2 are registered and stable from this cycle until the next ISSUE.
  - Wait counter=0. Go to WAIT.
- WAIT:
  - Count DP_LAT cycles after the ISSUE cycle.
  - On the cycle where count reaches DP_LAT, sample dp_sum into res_data and go to RESULT.
- RESULT:
  - res_valid=1; res_data, res_row, res_col held stable until res_valid&&res_ready.
  - On accept: if (i,j)=(N-1,N-1), go to DONE; else advance j (j wraps to 0 and increments i) and go to ISSUE.
  - res_valid may stay high indefinitely; there is no timeout.
- DONE:
  - done=1 for one cycle; counters i, j, e cleared; go to LOAD.
  - Matrices retained; next load overwrites them.
- Per-product latency, ISSUE to res_valid: 1+DP_LAT cycles (ISSUE cycle + DP_LAT WAIT cycles; res_valid on following edge).
- load_valid outside LOAD: ignored, load_ready=0, no write.
- dp_sum is passed through unmodified (sign handled by dot_product); this block does no arithmetic besides counters.
- Reset asserted mid-operation: immediate abort to reset values; a partial result is discarded; no done pulse.
- N=1: single product; row/col ports 1 bit, always 0.

Decomposition:
- Package matmul_pkg: state_t enum (LOAD, ISSUE, WAIT, RESULT, DONE); elem_t (signed DW); sum_t (signed SW); function idx_w(N) returning max(1,$clog2(N)).
- Packing/column gather is a generate loop inline; no sub-module.
- dot_product is instantiated beside this block at top level, not inside it.

Test Plan:
1. Load A={{1,2},{3,4}}, B={{1,2},{3,4}} with the real dot_product (N=2, DW=8, DP_LAT=1), res_ready=1. Required: results (0,0)=7, (0,1)=10, (1,0)=15, (1,1)=22 in that order, then one done pulse.
2. Same as 1, res_ready held low 5 cycles at each result. Required: res_data/res_row/res_col stable while stalled; no extra dp_enable pulses; same 4 values.
3. Toggle load_valid 1/0 during load; assert load_valid during RESULT. Required: exactly 8 writes; load_ready=0 after load; results as in 1.
4. Signed: A={{-1,2},{3,-4}}, B=identity. Required: results -1, 2, 3, -4; then A={{127,127},{127,127}}, B all -128 gives -32512 for all four.
5. Assert reset in WAIT of the third product, then reload the data from 1. Required: all outputs at reset values the same cycle; no done; fresh run gives 7, 10, 15, 22.
6. DP_LAT=3 with a stub returning a constant 0x55 three cycles after dp_enable. Required: ISSUE to res_valid = 4 cycles; res_data=0x55.
